// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - CPU-side request/response to wait-stated IO bus master.
// Optional address check enabled by macro IO_ADDR_CHECK_EN.
module io_bus_master #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [31:0] KEY_ADDR    = 32'h0000_7F00,
  parameter logic [31:0] LED_ADDR    = 32'h0000_7F04
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        io_ce,
  output logic        io_we,
  output logic [31:0] io_addr,
  output logic [31:0] io_wtData,
  input  logic [31:0] io_rdData
);

  localparam int CW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic          addr_ok;
  logic          in_access;
  logic          last_access;

`ifdef IO_ADDR_CHECK_EN
  assign addr_ok = (req_addr == KEY_ADDR) || (req_addr == LED_ADDR);
`else
  assign addr_ok = 1'b1;
`endif

  assign in_access   = (state == ACCESS);
  assign last_access = in_access && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = addr_ok ? ACCESS : RESP;
      ACCESS:  if (cnt == '0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt     <= CW'(WAIT_CYCLES);
            err_q   <= !addr_ok;
            // A rejected address goes straight to RESP, so its data is cleared here
            if (!addr_ok) rdata_q <= '0;
          end
        end
        ACCESS: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else           rdata_q <= we_q ? 32'h0 : io_rdData;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
`ifdef IO_ADDR_CHECK_EN
  assign resp_err   = err_q;
`else
  assign resp_err   = 1'b0 & err_q;
`endif

  // IO side is driven purely from state so an async reset silences it at once
  assign io_ce     = in_access;
  assign io_we     = last_access && we_q;
  assign io_addr   = in_access ? addr_q  : 32'h0;
  assign io_wtData = in_access ? wdata_q : 32'h0;

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - self-checking bench for io_bus_master.
// Honors IO_ADDR_CHECK_EN when the design is built with it.
module tb_io_bus_master;

  localparam int          W   = 2;
  localparam logic [31:0] KEY = 32'h0000_7F00;
  localparam logic [31:0] LED = 32'h0000_7F04;

  logic        clk, rst;
  logic        req_valid, req_ready, req_we, resp_valid, resp_ready, resp_err, io_ce, io_we;
  logic [31:0] req_addr, req_wdata, resp_rdata, io_addr, io_wtData, io_rdData;

  logic        z_req_valid, z_req_ready, z_resp_valid, z_resp_err, z_io_ce, z_io_we;
  logic [31:0] z_resp_rdata, z_io_addr, z_io_wtData;

  int checks = 0;
  int failures = 0;

  io_bus_master #(.WAIT_CYCLES(W), .KEY_ADDR(KEY), .LED_ADDR(LED)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .io_ce(io_ce), .io_we(io_we),
    .io_addr(io_addr), .io_wtData(io_wtData), .io_rdData(io_rdData)
  );

  io_bus_master #(.WAIT_CYCLES(0), .KEY_ADDR(KEY), .LED_ADDR(LED)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(1'b0),
    .req_addr(KEY), .req_wdata(32'h0), .resp_valid(z_resp_valid), .resp_ready(1'b1),
    .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .io_ce(z_io_ce), .io_we(z_io_we),
    .io_addr(z_io_addr), .io_wtData(z_io_wtData), .io_rdData(32'h0000_0042)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
`ifdef IO_ADDR_CHECK_EN
    return (a == KEY) || (a == LED);
`else
    return (a == a);
`endif
  endfunction

  // Transaction-timeline model: m_t is the number of cycles since acceptance,
  // 0 = idle, 1..W+1 = device access window, W+2 = response pending.
  int          m_t = 0;
  logic        m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err;
  bit          m_acc, m_rsp;

  always @(negedge clk) begin
    if (rst) begin
      m_t = 0;
    end else begin
      m_acc = (m_t >= 1) && (m_t <= W + 1);
      m_rsp = (m_t == W + 2);
      chk("m_req_ready",  req_ready,  32'(m_t == 0));
      chk("m_resp_valid", resp_valid, 32'(m_rsp));
      chk("m_io_ce",      io_ce,      32'(m_acc));
      chk("m_io_we",      io_we,      32'(m_acc && m_we && m_t == W + 1));
      chk("m_io_addr",    io_addr,    m_acc ? m_addr : 32'h0);
      chk("m_io_wtData",  io_wtData,  m_acc ? m_wdata : 32'h0);
      if (m_rsp) begin
        chk("m_resp_rdata", resp_rdata, m_rdata);
        chk("m_resp_err",   resp_err,   32'(m_err));
      end
      if (m_t == 0) begin
        if (req_valid) begin
          m_we = req_we; m_addr = req_addr; m_wdata = req_wdata;
          if (addr_ok(req_addr)) begin
            m_t = 1; m_err = 1'b0;
          end else begin
            m_t = W + 2; m_err = 1'b1; m_rdata = 32'h0;
          end
        end
      end else if (m_acc) begin
        if (m_t == W + 1) m_rdata = m_we ? 32'h0 : io_rdData;
        m_t++;
      end else if (resp_ready) begin
        m_t = 0;
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [31:0] a, input logic [31:0] d);
    chk("issue_ready", req_ready, 32'h1);
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  // Called one step after the accepting edge; lat counts cycles from the acceptance cycle.
  task automatic wait_resp(output int lat, output int ce_n, output int we_n, output logic [31:0] wt);
    lat = 1; ce_n = 0; we_n = 0; wt = 32'h0;
    while (!resp_valid && lat <= 20) begin
      if (io_ce) ce_n++;
      if (io_we) begin we_n++; wt = io_wtData; end
      step();
      lat++;
    end
    chk("resp_timeout", 32'(resp_valid), 32'h1);
  endtask

  int          lat, ce_n, we_n;
  logic [31:0] wt;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    resp_ready = 1'b1; io_rdData = '0; z_req_valid = 1'b0;
    step();
    chk("rst_req_ready", req_ready, 32'h1);
    chk("rst_resp_valid", resp_valid, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", resp_err, 32'h0);
    chk("rst_io_ce", io_ce, 32'h0);
    chk("rst_io_we", io_we, 32'h0);
    chk("rst_io_addr", io_addr, 32'h0);
    chk("rst_io_wtData", io_wtData, 32'h0);
    chk("rst_z_ready", z_req_ready, 32'h1);
    step();
    rst = 1'b0;

    // WAIT_CYCLES=0 back-to-back: idle, access, resp repeating every 3 cycles
    z_req_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      chk("b2b_ready", z_req_ready, 32'(i % 3 == 0));
      chk("b2b_ce", z_io_ce, 32'(i % 3 == 1));
      chk("b2b_resp", z_resp_valid, 32'(i % 3 == 2));
      if (i % 3 == 2) chk("b2b_rdata", z_resp_rdata, 32'h0000_0042);
      step();
    end
    z_req_valid = 1'b0;
    step();

    // Read KEY with slow consumer, then hold RESP with a competing request
    resp_ready = 1'b0;
    io_rdData = 32'h1;
    issue(1'b0, KEY, 32'h0);
    wait_resp(lat, ce_n, we_n, wt);
    chk("rd_latency", lat, 32'd4);
    chk("rd_ce_cycles", ce_n, 32'd3);
    chk("rd_we_count", we_n, 32'd0);
    chk("rd_rdata", resp_rdata, 32'h1);
    chk("rd_err", resp_err, 32'h0);
    io_rdData = 32'h5555_0000;
    req_valid = 1'b1; req_we = 1'b1; req_addr = LED; req_wdata = 32'h0000_0F0F;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_resp_valid", resp_valid, 32'h1);
      chk("hold_rdata", resp_rdata, 32'h1);
      chk("hold_ready", req_ready, 32'h0);
      chk("hold_io_ce", io_ce, 32'h0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    step();
    chk("release_ready", req_ready, 32'h1);

    // Write LED: one strobe in the last access cycle
    issue(1'b1, LED, 32'h0000_A5A5);
    wait_resp(lat, ce_n, we_n, wt);
    chk("wr_latency", lat, 32'd4);
    chk("wr_ce_cycles", ce_n, 32'd3);
    chk("wr_we_count", we_n, 32'd1);
    chk("wr_we_data", wt, 32'h0000_A5A5);
    chk("wr_rdata", resp_rdata, 32'h0);
    step();

    // Unmapped address
    io_rdData = 32'hDEAD_BEEF;
    issue(1'b0, 32'h0000_1234, 32'h0);
    wait_resp(lat, ce_n, we_n, wt);
`ifdef IO_ADDR_CHECK_EN
    chk("bad_latency", lat, 32'd1);
    chk("bad_ce_cycles", ce_n, 32'd0);
    chk("bad_err", resp_err, 32'h1);
    chk("bad_rdata", resp_rdata, 32'h0);
`else
    chk("bad_latency", lat, 32'd4);
    chk("bad_ce_cycles", ce_n, 32'd3);
    chk("bad_err", resp_err, 32'h0);
    chk("bad_rdata", resp_rdata, 32'hDEAD_BEEF);
`endif
    step();

    // Reset during the second access cycle of a write
    issue(1'b1, LED, 32'h0000_1111);
    chk("abort_c1_ce", io_ce, 32'h1);
    step();
    chk("abort_c2_ce", io_ce, 32'h1);
    #1 rst = 1'b1;
    #1;
    chk("abort_io_ce", io_ce, 32'h0);
    chk("abort_io_we", io_we, 32'h0);
    chk("abort_io_addr", io_addr, 32'h0);
    chk("abort_ready", req_ready, 32'h1);
    chk("abort_resp_valid", resp_valid, 32'h0);
    chk("abort_rdata", resp_rdata, 32'h0);
    step();
    step();
    rst = 1'b0;
    ce_n = 0; we_n = 0; lat = 0;
    for (int i = 0; i < 8; i++) begin
      if (io_we) we_n++;
      if (io_ce) ce_n++;
      if (resp_valid) lat++;
      step();
    end
    chk("abort_no_we", we_n, 32'd0);
    chk("abort_no_ce", ce_n, 32'd0);
    chk("abort_no_resp", lat, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/io_bus_master.md
IO_BUS_MASTER -- requirements
Module: io_bus_master

Interface
REQ-001 The block SHALL have the following parameters, one per line (name, default, meaning):
- WAIT_CYCLES, 2, extra cycles io_ce is held before read sampling or the write strobe.
- KEY_ADDR, 32'h0000_7F00, address of the key input register.
- LED_ADDR, 32'h0000_7F04, address of the LED output register.
REQ-002 The block SHALL have the following ports, one per line (name, direction, width, meaning):
- clk, in, 1, the single clock; all state updates on its rising edge.
- rst, in, 1, asynchronous active-high reset.
- req_valid, in, 1, the CPU side presents an IO request.
- req_ready, out, 1, the block accepts a request this cycle.
- req_we, in, 1, 1 = write, 0 = read.
- req_addr, in, 32, request address.
- req_wdata, in, 32, write data.
- resp_valid, out, 1, response available.
- resp_ready, in, 1, the CPU side consumes the response.
- resp_rdata, out, 32, read data (0 for writes).
- resp_err, out, 1, address error flag.
- io_ce, out, 1, IO device chip enable.
- io_we, out, 1, IO device write strobe.
- io_addr, out, 32, IO device address.
- io_wtData, out, 32, IO device write data.
- io_rdData, in, 32, IO device combinational read data.

Function
REQ-003 The FSM SHALL have states IDLE, ACCESS and RESP; reset state is IDLE.
REQ-004 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-005 On a clock edge with req_valid=1 in IDLE, the block SHALL latch req_we, req_addr and req_wdata, load the wait counter with WAIT_CYCLES, and enter ACCESS.
REQ-006 In ACCESS, io_ce SHALL be 1 and io_addr/io_wtData SHALL equal the latched values; in ACCESS the counter SHALL decrement by 1 per cycle while non-zero.
REQ-007 io_we SHALL be 1 only in the ACCESS cycle where the counter equals 0, and only for write requests, giving exactly one write strobe per write.
REQ-008 On the edge ending the ACCESS cycle where the counter equals 0, a read SHALL capture io_rdData into resp_rdata and a write SHALL clear resp_rdata to 0; the FSM SHALL then enter RESP.
REQ-009 ACCESS SHALL last exactly WAIT_CYCLES+1 cycles; WAIT_CYCLES=0 SHALL give a single ACCESS cycle.
REQ-010 Outside ACCESS, io_ce, io_we, io_addr and io_wtData SHALL all be 0.
REQ-011 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_err SHALL be held stable until an edge with resp_ready=1, after which the FSM SHALL enter IDLE.
REQ-012 A request presented while req_ready=0 SHALL be ignored and SHALL NOT disturb the transaction in flight.
REQ-013 Latency from request acceptance to resp_valid SHALL be WAIT_CYCLES+2 cycles.
REQ-014 resp_valid SHALL remain 1 indefinitely while resp_ready=0, with no further IO activity.

Reset
REQ-015 Asserting rst SHALL immediately, without waiting for a clock edge, force the following: IDLE state, counter=0, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, io_ce=0, io_we=0, io_addr=0, io_wtData=0.
REQ-016 Reset asserted during ACCESS SHALL abort the access with no io_we pulse after assertion; no response for the aborted request SHALL be produced.

Configuration
REQ-017 With macro IO_ADDR_CHECK_EN defined, a request whose address equals neither KEY_ADDR nor LED_ADDR SHALL skip ACCESS with io_ce kept 0, enter RESP on the next edge with resp_err=1 and resp_rdata=0, and produce a latency of 1 cycle.
REQ-018 With IO_ADDR_CHECK_EN undefined, resp_err SHALL be constant 0 and every address SHALL be accessed per REQ-005..REQ-009.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Read KEY_ADDR with io_rdData=32'h1 and WAIT_CYCLES=2 -> io_ce high for 3 cycles, resp_valid 4 cycles after acceptance, resp_rdata=32'h1, resp_err=0.
- Write LED_ADDR with data 32'h0000_A5A5 -> exactly one io_we pulse with io_wtData=32'h0000_A5A5 in the last ACCESS cycle, then resp_rdata=0.
- Hold resp_ready=0 for 5 cycles in RESP while req_valid=1 -> resp_valid and resp_rdata are stable, req_ready=0, and no new io_ce occurs.
- Assert rst in the second ACCESS cycle of a write -> io_ce=0 and io_we=0 immediately, and no response is produced.
- With IO_ADDR_CHECK_EN, read 32'h0000_1234 -> io_ce never asserts and resp_err=1 one cycle later; without the macro, the same read accesses the device with resp_err=0.
- With WAIT_CYCLES=0, back-to-back requests with resp_ready=1 -> one ACCESS cycle each, and a new acceptance every 3 cycles.
